div_dispatch: RTL
=================

# div_dispatch

Request/response front-end that sits directly upstream of the signed sequential divider in the ALU. It accepts a tagged (dividend, divisor) request, screens the special cases (divide-by-zero, signed overflow), drives the divider's begin/operand bus, and waits for its finish pulse. It then sign-corrects the remainder and returns quotient, remainder and status on a valid/ready response port. A watchdog guards against a divider that never finishes.

## Interface
- WIDTH, 32: operand and result width.
- TAG_W, 4: request tag width.
- TIMEOUT, 255: maximum cycles spent in WAIT before aborting; ≥ 2*WIDTH+8.
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_tag  in  TAG_W  tag returned with the response.
- req_a  in  WIDTH  signed dividend.
- req_b  in  WIDTH  signed divisor.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_quo  out  WIDTH  signed quotient.
- rsp_rem  out  WIDTH  signed remainder; its sign follows the dividend.
- rsp_status  out  2  0=OK, 1=DBZ, 2=OVF, 3=TIMEOUT.
- div_bgn  out  1  one-cycle start pulse to the divider.
- div_opa  out  WIDTH  dividend to the divider's ibusA.
- div_opb  out  WIDTH  divisor to the divider's ibusB.
- div_fin  in  1  divider finished; results valid this cycle only.
- div_quo  in  WIDTH  divider obusA, sign-corrected quotient.
- div_rem  in  WIDTH  divider obusB, remainder magnitude.
- div_hung  out  1  sticky; set on timeout and cleared only by rst.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid&req_ready) latches tag, a and b.
  - If b==0: result q=all ones, r=a, status DBZ; go to RESP.
  - Else if a==MIN and b==-1: result q=MIN, r=0, status OVF; go to RESP.
  - Else if div_hung: result q=0, r=0, status TIMEOUT; go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_bgn=1 for exactly this cycle.
  - Go to WAIT and clear the watchdog.
- WAIT:
  - Watchdog increments every cycle.
  - On div_fin: capture q=div_quo and r = a[WIDTH-1] ? -div_rem : div_rem (two's complement, WIDTH bits); status OK; go to RESP.
  - On watchdog==TIMEOUT without div_fin: q=0, r=0, status TIMEOUT, set div_hung; go to RESP.
  - div_fin and expiry in the same cycle: div_fin wins.
- RESP:
  - rsp_valid=1; all rsp_* outputs are held stable.
  - On rsp_ready, go to IDLE.
- div_fin outside WAIT is ignored.
- div_opa/div_opb are registered copies of the latched operands. They hold from ISSUE through WAIT and change only on a new IDLE handshake.
- Reset (at any point, including mid-WAIT):
  - state=IDLE; every output 0 except req_ready=1.
  - Watchdog=0; div_hung=0.
  - The divider must be reset in the same cycle by the system.

## Timing
- Handshake in cycle 0 leads to div_bgn=1 in cycle 1 and WAIT from cycle 2.
- div_fin sampled in cycle N leads to rsp_valid=1 in cycle N+1.
- Special cases (DBZ/OVF/hung): rsp_valid=1 in cycle 1; div_bgn never pulses.
- Timeout: rsp_valid in the cycle after watchdog reaches TIMEOUT, which is TIMEOUT+2 cycles after ISSUE.
- Minimum request-to-request spacing is 2 cycles, because req_ready is low for the whole of RESP.
- All outputs are registered; there is no combinational path from req_* or div_* to any output.

## Structure
- Shared package alu_div_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the status enum (OK/DBZ/OVF/TIMEOUT);
  - the MIN constant, {1'b1,{WIDTH-1{1'b0}}}.
- One sub-module: div_watchdog. It is a clearable up-counter of width $clog2(TIMEOUT+1) with a terminal-count flag.
- Remainder negation stays inline.

## Test plan
- 100/7, divider model fin after 40 cycles -> rsp_quo=14, rsp_rem=2, status OK, tag echoed; div_bgn pulses once.
- -100/7 (0xFFFFFF9C/7), divider model returns quo=0xFFFFFFF2, rem magnitude=2 -> rsp_quo=0xFFFFFFF2, rsp_rem=0xFFFFFFFE.
- 5/0 -> rsp_valid in cycle 1, quo=0xFFFFFFFF, rem=5, status DBZ; div_bgn never asserted.
- 0x80000000 / 0xFFFFFFFF -> quo=0x80000000, rem=0, status OVF; div_bgn never asserted.
- div_fin held low -> status TIMEOUT at ISSUE+TIMEOUT+2 and div_hung=1. Next request 10/2 gets immediate TIMEOUT; rst clears div_hung.
- Backpressure and reset:
  - rsp_ready low 5 cycles -> rsp_* stable and req_ready=0 throughout.
  - rst asserted mid-WAIT -> next cycle IDLE, rsp_valid=0, req_ready=1, and a late div_fin is ignored.

Source files
------------

// File: rtl/alu_div_pkg.sv
// Shared types and constants for the divider dispatch front-end.
// Holds the FSM state encoding, the response status codes and the signed minimum operand.
package alu_div_pkg;

  localparam int DIV_WIDTH = 32;

  // Most negative signed operand; MIN / -1 overflows the quotient.
  localparam logic [DIV_WIDTH-1:0] MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_DBZ     = 2'd1,
    STAT_OVF     = 2'd2,
    STAT_TIMEOUT = 2'd3
  } div_status_e;

endpackage

// File: rtl/div_watchdog.sv
// Clearable up-counter that stops at TIMEOUT and flags the terminal count.
// Guards the dispatcher against a divider that never returns its finish pulse.
module div_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Saturates at the limit so a stale expiry can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/div_dispatch.sv
// Request/response front-end for the signed sequential divider: screens DBZ/OVF,
// issues the operands, waits for the finish pulse under a watchdog and returns the result.
module div_dispatch
  import alu_div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [WIDTH-1:0] rsp_quo,
  output logic [WIDTH-1:0] rsp_rem,
  output logic [1:0]       rsp_status,
  output logic             div_bgn,
  output logic [WIDTH-1:0] div_opa,
  output logic [WIDTH-1:0] div_opb,
  input  logic             div_fin,
  input  logic [WIDTH-1:0] div_quo,
  input  logic [WIDTH-1:0] div_rem,
  output logic             div_hung,
  output div_state_e       dbg_state
);

  localparam logic [WIDTH-1:0] OP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never waits on ready, and once raised rsp_valid and all rsp_*
  // stay put until the transfer completes. req_ready is high only in IDLE.

  div_state_e       state_q, state_d;
  logic             hs;
  logic             wd_clr, wd_en, wd_tc;
  logic             load_rsp, set_hung;
  logic [WIDTH-1:0] quo_d, rem_d;
  div_status_e      status_d;

  assign hs     = req_valid & req_ready;
  assign wd_clr = (state_q == ST_ISSUE);
  assign wd_en  = (state_q == ST_WAIT);

  div_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_tc)
  );

  always_comb begin
    state_d  = state_q;
    load_rsp = 1'b0;
    set_hung = 1'b0;
    quo_d    = '0;
    rem_d    = '0;
    status_d = STAT_OK;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (req_b == '0) begin
            load_rsp = 1'b1;
            quo_d    = '1;
            rem_d    = req_a;
            status_d = STAT_DBZ;
            state_d  = ST_RESP;
          end else if (req_a == OP_MIN && req_b == '1) begin
            load_rsp = 1'b1;
            quo_d    = OP_MIN;
            status_d = STAT_OVF;
            state_d  = ST_RESP;
          end else if (div_hung) begin
            // A hung divider is never handed new work until rst.
            load_rsp = 1'b1;
            status_d = STAT_TIMEOUT;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_fin) begin
          load_rsp = 1'b1;
          quo_d    = div_quo;
          rem_d    = div_opa[WIDTH-1] ? -div_rem : div_rem;
          status_d = STAT_OK;
          state_d  = ST_RESP;
        end else if (wd_tc) begin
          load_rsp = 1'b1;
          set_hung = 1'b1;
          status_d = STAT_TIMEOUT;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_tag    <= '0;
      rsp_quo    <= '0;
      rsp_rem    <= '0;
      rsp_status <= '0;
      div_bgn    <= 1'b0;
      div_opa    <= '0;
      div_opb    <= '0;
      div_hung   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
      div_bgn   <= (state_d == ST_ISSUE);
      if (hs) begin
        rsp_tag <= req_tag;
        div_opa <= req_a;
        div_opb <= req_b;
      end
      if (load_rsp) begin
        rsp_quo    <= quo_d;
        rsp_rem    <= rem_d;
        rsp_status <= status_d;
      end
      if (set_hung) div_hung <= 1'b1;
    end
  end

  assign dbg_state = state_q;

endmodule
